bnn_xnor_fc_engine: RTL and testbench

- Sequential, parametrised binary fully-connected layer engine; successor to the combinational XNOR/accumulate layer.
- Latches one binarised input vector across CH_CNT independent channels.
- Streams signed XNOR-popcount dot products for OUT_PAR neurons per beat, from an internal weight/threshold store.
- Optionally binarises each result against a per-neuron threshold; sits between the binarised activation buffer and the next layer's input FIFO.

---
 rtl/bnn_xnor_fc_engine.sv | 195 +++++++++++++++++++
 tb/tb_bnn_xnor_fc_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_xnor_fc_engine.sv
// bnn_xnor_fc_engine
// Sequential binary fully-connected layer. It latches one binarised input
// vector that holds CH_CNT independent channels. It then streams XNOR-popcount
// dot products for OUT_PAR neurons per beat, G beats per vector. Each result is
// also binarised against a per-neuron signed threshold. Weights and thresholds
// live in an internal register store that can be written only while idle.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  input vector handshake
//   in_data_i              bit [c*IN_DIM+j] = input j of channel c (1 => +1)
//   w_we_i/w_ready_o       weight/threshold write strobe, accepted while idle
//   w_addr_i               neuron index of the row being written
//   w_data_i, th_data_i    weight row and signed threshold for that neuron
//   out_valid_o/out_ready_i result beat handshake
//   out_data_o             signed dot products, slot [p*CH_CNT+c]
//   out_bin_o              binarised results, same slot order
//   out_idx_o, out_last_o  beat (group) index, final-beat marker
module bnn_xnor_fc_engine #(
   parameter int IN_DIM  = 64,
   parameter int OUT_DIM = 16,
   parameter int CH_CNT  = 4,
   parameter int OUT_PAR = 2,
   parameter int ACC_W   = $clog2(IN_DIM + 1) + 1,
   parameter int G       = OUT_DIM / OUT_PAR,
   parameter int ADDR_W  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
   parameter int IDX_W   = (G > 1) ? $clog2(G) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [IN_DIM*CH_CNT-1:0]          in_data_i,
   input  logic                              w_we_i,
   output logic                              w_ready_o,
   input  logic [ADDR_W-1:0]                 w_addr_i,
   input  logic [IN_DIM-1:0]                 w_data_i,
   input  logic [ACC_W-1:0]                  th_data_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [OUT_PAR*CH_CNT*ACC_W-1:0]   out_data_o,
   output logic [OUT_PAR*CH_CNT-1:0]         out_bin_o,
   output logic [IDX_W-1:0]                  out_idx_o,
   output logic                              out_last_o
);

   // The group counter runs one past the last group so that "no groups left"
   // is simply g_q == G.
   localparam int CNT_W = $clog2(G + 1);
   localparam logic [CNT_W-1:0] G_CNT = CNT_W'(G);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
   localparam logic [ACC_W-1:0] IN_DIM_ACC = ACC_W'(IN_DIM);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                            state_q, state_d;
   logic [IN_DIM*CH_CNT-1:0]          in_q, in_d;
   logic [CNT_W-1:0]                  g_q, g_d;
   logic                              out_valid_q, out_valid_d;
   logic [OUT_PAR*CH_CNT*ACC_W-1:0]   out_data_q, out_data_d;
   logic [OUT_PAR*CH_CNT-1:0]         out_bin_q, out_bin_d;
   logic [IDX_W-1:0]                  out_idx_q, out_idx_d;
   logic                              out_last_q, out_last_d;
   logic [IN_DIM-1:0]                 weight_q [OUT_DIM];
   logic [IN_DIM-1:0]                 weight_d [OUT_DIM];
   logic [ACC_W-1:0]                  th_q [OUT_DIM];
   logic [ACC_W-1:0]                  th_d [OUT_DIM];

   logic [OUT_PAR*CH_CNT*ACC_W-1:0]   beat_data;
   logic [OUT_PAR*CH_CNT-1:0]         beat_bin;
   logic [CNT_W-1:0]                  g_sel;
   logic                              out_hs;

   function automatic logic [ACC_W-1:0] popcnt(input logic [IN_DIM-1:0] v);
      logic [ACC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < IN_DIM; i++) begin
         cnt = cnt + ACC_W'(v[i]);
      end
      return cnt;
   endfunction

   assign in_ready_o  = (state_q == IDLE);
   assign w_ready_o   = (state_q == IDLE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_bin_o   = out_bin_q;
   assign out_idx_o   = out_idx_q;
   assign out_last_o  = out_last_q;
   assign out_hs      = out_valid_q & out_ready_i;

   // Datapath for the group addressed by g_q. When g_q == G the selection
   // folds back to group 0 so the store is never indexed out of range. That
   // value is never loaded in that case.
   always_comb begin
      beat_data = '0;
      beat_bin  = '0;
      g_sel     = (g_q < G_CNT) ? g_q : '0;
      for (int p = 0; p < OUT_PAR; p++) begin
         for (int c = 0; c < CH_CNT; c++) begin
            logic [ADDR_W-1:0] n;
            logic [ACC_W-1:0]  pop;
            logic [ACC_W-1:0]  dot;
            n   = ADDR_W'(int'(g_sel) * OUT_PAR + p);
            pop = popcnt(~(weight_q[n] ^ in_q[c*IN_DIM +: IN_DIM]));
            // 2*pop fits unsigned in ACC_W. Subtracting IN_DIM modulo
            // 2^ACC_W gives the correct two's complement result.
            dot = (pop << 1) - IN_DIM_ACC;
            beat_data[(p*CH_CNT+c)*ACC_W +: ACC_W] = dot;
            beat_bin[p*CH_CNT+c] = ($signed(dot) >= $signed(th_q[n]));
         end
      end
   end

   // Next-state logic. Weight writes are gated by w_ready_o, so writes made
   // while busy are dropped. A write in the handshake cycle lands before the
   // first group is computed.
   always_comb begin
      state_d     = state_q;
      in_d        = in_q;
      g_d         = g_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_bin_d   = out_bin_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      weight_d    = weight_q;
      th_d        = th_q;

      if (w_we_i && w_ready_o && (int'(w_addr_i) < OUT_DIM)) begin
         weight_d[w_addr_i] = w_data_i;
         th_d[w_addr_i]     = th_data_i;
      end

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               in_d    = in_data_i;
               g_d     = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (out_hs && out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = IDLE;
            end else if ((!out_valid_q || out_hs) && (g_q < G_CNT)) begin
               out_valid_d = 1'b1;
               out_data_d  = beat_data;
               out_bin_d   = beat_bin;
               out_idx_d   = g_q[IDX_W-1:0];
               out_last_d  = (g_q == G_CNT - ONE_CNT);
               g_d         = g_q + ONE_CNT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, result and weight-store registers. Reset also clears the store.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         in_q        <= '0;
         g_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_bin_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < OUT_DIM; i++) begin
            weight_q[i] <= '0;
            th_q[i]     <= '0;
         end
      end else begin
         state_q     <= state_d;
         in_q        <= in_d;
         g_q         <= g_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_bin_q   <= out_bin_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         for (int i = 0; i < OUT_DIM; i++) begin
            weight_q[i] <= weight_d[i];
            th_q[i]     <= th_d[i];
         end
      end
   end

endmodule

// File: tb/tb_bnn_xnor_fc_engine.sv
// Directed testbench for bnn_xnor_fc_engine.
// Configuration: IN_DIM=8, OUT_DIM=4, CH_CNT=2, OUT_PAR=2, so ACC_W=5 and G=2.
// Expected dot products and bins are hand-computed constants.
module tb_bnn_xnor_fc_engine;

   localparam int IN_DIM  = 8;
   localparam int OUT_DIM = 4;
   localparam int CH_CNT  = 2;
   localparam int OUT_PAR = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] in_data_i;
   logic        w_we_i;
   logic        w_ready_o;
   logic [1:0]  w_addr_i;
   logic [7:0]  w_data_i;
   logic [4:0]  th_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [19:0] out_data_o;
   logic [3:0]  out_bin_o;
   logic [0:0]  out_idx_o;
   logic        out_last_o;

   int checks = 0;
   int errors = 0;

   bnn_xnor_fc_engine #(
      .IN_DIM (IN_DIM),
      .OUT_DIM(OUT_DIM),
      .CH_CNT (CH_CNT),
      .OUT_PAR(OUT_PAR)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .w_we_i     (w_we_i),
      .w_ready_o  (w_ready_o),
      .w_addr_i   (w_addr_i),
      .w_data_i   (w_data_i),
      .th_data_i  (th_data_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o (out_data_o),
      .out_bin_o  (out_bin_o),
      .out_idx_o  (out_idx_o),
      .out_last_o (out_last_o)
   );

   // 10 time-unit clock
   always #5 clk_i = ~clk_i;

   // Advance past the next rising edge and settle, so sampling stays clear of it
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One comparison: count it, and report it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Pack four signed slot values (slot 0 first) into the out_data layout
   function automatic logic [19:0] pack(input int d0, input int d1,
                                        input int d2, input int d3);
      return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
   endfunction

   // Compare one complete visible beat
   task automatic checkBeat(input string tag, input int idx, input int last,
                            input logic [19:0] data, input logic [3:0] bin);
      checkOutput({tag, ".valid"}, out_valid_o, 1);
      checkOutput({tag, ".idx"}, out_idx_o, idx);
      checkOutput({tag, ".last"}, out_last_o, last);
      checkOutput({tag, ".data"}, out_data_o, data);
      checkOutput({tag, ".bin"}, out_bin_o, bin);
   endtask

   // Write one weight row and its threshold during a single cycle
   task automatic writeRow(input logic [1:0] addr, input logic [7:0] data,
                           input logic [4:0] th);
      w_we_i    = 1'b1;
      w_addr_i  = addr;
      w_data_i  = data;
      th_data_i = th;
      tick();
      w_we_i    = 1'b0;
   endtask

   // Present one input vector for a single cycle while the engine is idle
   task automatic applyStimulus(input logic [7:0] ch0, input logic [7:0] ch1);
      in_valid_i = 1'b1;
      in_data_i  = {ch1, ch0};
      tick();
      in_valid_i = 1'b0;
   endtask

   // Last-resort guard so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Directed sequence
   initial begin
      int accCnt;
      int firstAcc;
      int secondAcc;
      int beatCnt;
      int idxSeq [8];

      rst_ni      = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      w_we_i      = 1'b0;
      w_addr_i    = '0;
      w_data_i    = '0;
      th_data_i   = '0;
      out_ready_i = 1'b0;

      // Reset state
      #2;
      checkOutput("rst.out_valid", out_valid_o, 0);
      checkOutput("rst.in_ready", in_ready_o, 1);
      checkOutput("rst.w_ready", w_ready_o, 1);
      checkOutput("rst.out_data", out_data_o, 0);
      checkOutput("rst.out_bin", out_bin_o, 0);
      checkOutput("rst.out_idx", out_idx_o, 0);
      checkOutput("rst.out_last", out_last_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // All rows 0xFF, thresholds 0, ch0=0xFF ch1=0x00
      for (int i = 0; i < 4; i++) writeRow(2'(i), 8'hFF, 5'd0);
      out_ready_i = 1'b1;
      applyStimulus(8'hFF, 8'h00);
      checkOutput("t1.in_ready_busy", in_ready_o, 0);
      checkOutput("t1.valid_latch", out_valid_o, 0);
      tick();
      checkBeat("t1.b0", 0, 0, pack(8, -8, 8, -8), 4'b0101);
      tick();
      checkBeat("t1.b1", 1, 1, pack(8, -8, 8, -8), 4'b0101);
      tick();
      checkOutput("t1.valid_end", out_valid_o, 0);
      checkOutput("t1.in_ready_end", in_ready_o, 1);

      // Row0=0xF0 th 0, ch0=0xAA ch1=0x0F, with beat 0 held for 3 cycles
      writeRow(2'd0, 8'hF0, 5'd0);
      out_ready_i = 1'b0;
      applyStimulus(8'hAA, 8'h0F);
      tick();
      checkBeat("t2.hold1", 0, 0, pack(0, -8, 0, 0), 4'b1101);
      tick();
      checkBeat("t2.hold2", 0, 0, pack(0, -8, 0, 0), 4'b1101);
      tick();
      checkBeat("t2.hold3", 0, 0, pack(0, -8, 0, 0), 4'b1101);
      out_ready_i = 1'b1;
      tick();
      checkBeat("t2.b1", 1, 1, pack(0, 0, 0, 0), 4'b1111);
      tick();
      checkOutput("t2.valid_end", out_valid_o, 0);
      checkOutput("t2.in_ready_end", in_ready_o, 1);

      // Row0 threshold 1 turns the equality case off
      writeRow(2'd0, 8'hF0, 5'd1);
      applyStimulus(8'hAA, 8'h0F);
      tick();
      checkBeat("t3.b0", 0, 0, pack(0, -8, 0, 0), 4'b1100);
      tick();
      tick();

      // Write to row1 while busy is dropped
      applyStimulus(8'hFF, 8'h00);
      checkOutput("t4.w_ready_busy", w_ready_o, 0);
      w_we_i    = 1'b1;
      w_addr_i  = 2'd1;
      w_data_i  = 8'h00;
      th_data_i = 5'd0;
      tick();
      w_we_i    = 1'b0;
      checkBeat("t4.vecA", 0, 0, pack(0, 0, 8, -8), 4'b0100);
      tick();
      tick();
      checkOutput("t4.in_ready_A", in_ready_o, 1);
      applyStimulus(8'hFF, 8'h00);
      tick();
      checkBeat("t4.vecB", 0, 0, pack(0, 0, 8, -8), 4'b0100);
      tick();
      tick();

      // Same write together with an input handshake in idle: both land
      w_we_i     = 1'b1;
      w_addr_i   = 2'd1;
      w_data_i   = 8'h00;
      th_data_i  = 5'd0;
      in_valid_i = 1'b1;
      in_data_i  = {8'h00, 8'hFF};
      tick();
      w_we_i     = 1'b0;
      in_valid_i = 1'b0;
      tick();
      checkBeat("t4.vecC", 0, 0, pack(0, 0, -8, 8), 4'b1000);
      tick();
      tick();

      // Reset while beat 1 is stalled
      applyStimulus(8'h55, 8'h55);
      tick();
      tick();
      out_ready_i = 1'b0;
      tick();
      checkOutput("t5.idx_stall", out_idx_o, 1);
      checkOutput("t5.valid_stall", out_valid_o, 1);
      rst_ni = 1'b0;
      #1;
      checkOutput("t5.valid_rst", out_valid_o, 0);
      checkOutput("t5.in_ready_rst", in_ready_o, 1);
      checkOutput("t5.data_rst", out_data_o, 0);
      #2;
      rst_ni = 1'b1;
      out_ready_i = 1'b1;
      tick();
      applyStimulus(8'h00, 8'h00);
      tick();
      checkBeat("t5.b0", 0, 0, pack(8, 8, 8, 8), 4'b1111);
      tick();
      checkBeat("t5.b1", 1, 1, pack(8, 8, 8, 8), 4'b1111);
      tick();

      // in_valid held high: acceptance every G+2 cycles, idx 0,1,0,1
      accCnt    = 0;
      firstAcc  = -1;
      secondAcc = -1;
      beatCnt   = 0;
      foreach (idxSeq[i]) idxSeq[i] = -1;
      in_data_i  = 16'h0000;
      in_valid_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (in_ready_o) begin
            if (accCnt == 0) firstAcc = k;
            else if (accCnt == 1) secondAcc = k;
            accCnt++;
         end
         if (out_valid_o) begin
            if (beatCnt < 8) idxSeq[beatCnt] = int'(out_idx_o);
            beatCnt++;
         end
         tick();
      end
      in_valid_i = 1'b0;
      checkOutput("t6.accepts", accCnt, 2);
      checkOutput("t6.period", secondAcc - firstAcc, 4);
      checkOutput("t6.beats", beatCnt, 4);
      checkOutput("t6.idx0", idxSeq[0], 0);
      checkOutput("t6.idx1", idxSeq[1], 1);
      checkOutput("t6.idx2", idxSeq[2], 0);
      checkOutput("t6.idx3", idxSeq[3], 1);
      checkOutput("t6.in_ready_end", in_ready_o, 1);
      checkOutput("t6.valid_end", out_valid_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
